// File: rtl/cpu_wb_arbiter.sv
// Writeback arbiter and register scoreboard for the CPU register file port.
// Ports: clk_i/rst_i (sync, active-high); issue_* and raddr*/hazard* toward
// decode; alu_*/lsu_* valid/ready result inputs; waddr_o/wdata_o/write_en_o
// registered register-file write port; err_o sticky unexpected-result flag.
module cpu_wb_arbiter #(
   parameter int CNT_W = 2
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        issue_valid_i,
   input  logic [4:0]  issue_rd_i,
   output logic        issue_ready_o,
   input  logic [4:0]  raddr1_i,
   input  logic [4:0]  raddr2_i,
   output logic        hazard1_o,
   output logic        hazard2_o,
   input  logic        alu_valid_i,
   input  logic [4:0]  alu_rd_i,
   input  logic [31:0] alu_data_i,
   output logic        alu_ready_o,
   input  logic        lsu_valid_i,
   input  logic [4:0]  lsu_rd_i,
   input  logic [31:0] lsu_data_i,
   output logic        lsu_ready_o,
   output logic [4:0]  waddr_o,
   output logic [31:0] wdata_o,
   output logic        write_en_o,
   output logic        err_o
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   logic [CNT_W-1:0] cnt [1:31];
   logic [CNT_W-1:0] cnt_all [32];
   logic             prio;
   logic             gnt_alu;
   logic             gnt_lsu;
   logic             grant;
   logic             issue_fire;
   logic             retire_hit;
   logic             err_set;
   logic [4:0]       sel_rd;
   logic [31:0]      sel_data;

   // x0 has no counter; expose a full 32-entry view that reads 0 there
   always_comb begin
      cnt_all[0] = '0;
      for (int i = 1; i < 32; i++) begin
         cnt_all[i] = cnt[i];
      end
   end

   assign issue_ready_o = (issue_rd_i == 5'd0) ||
                          (cnt_all[issue_rd_i] != CNT_MAX);
   assign issue_fire    = issue_valid_i && issue_ready_o &&
                          (issue_rd_i != 5'd0);

   assign hazard1_o = cnt_all[raddr1_i] != '0;
   assign hazard2_o = cnt_all[raddr2_i] != '0;

   // prio=1 lets the ALU win a tie, prio=0 the LSU
   assign gnt_alu = alu_valid_i && (!lsu_valid_i || prio);
   assign gnt_lsu = lsu_valid_i && (!alu_valid_i || !prio);
   assign grant   = gnt_alu || gnt_lsu;

   assign alu_ready_o = gnt_alu;
   assign lsu_ready_o = gnt_lsu;

   assign sel_rd   = gnt_alu ? alu_rd_i : lsu_rd_i;
   assign sel_data = gnt_alu ? alu_data_i : lsu_data_i;

   // A retire of the same register this edge already consumes one pending
   // write, so a single outstanding write leaves nothing for this result.
   assign retire_hit = write_en_o && (waddr_o == sel_rd);
   assign err_set    = grant && (sel_rd != 5'd0) &&
                       ((cnt_all[sel_rd] == '0) ||
                        (retire_hit && (cnt_all[sel_rd] == CNT_ONE)));

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         prio       <= 1'b0;
         write_en_o <= 1'b0;
         waddr_o    <= '0;
         wdata_o    <= '0;
         err_o      <= 1'b0;
         for (int i = 1; i < 32; i++) begin
            cnt[i] <= '0;
         end
      end else begin
         if (alu_valid_i && lsu_valid_i) begin
            prio <= !prio;
         end
         write_en_o <= grant && (sel_rd != 5'd0);
         if (grant) begin
            waddr_o <= sel_rd;
            wdata_o <= sel_data;
         end
         if (err_set) begin
            err_o <= 1'b1;
         end
         // inc and dec together cancel; dec saturates at zero
         for (int i = 1; i < 32; i++) begin
            if (issue_fire && (issue_rd_i == 5'(i)) &&
                !(write_en_o && (waddr_o == 5'(i)))) begin
               cnt[i] <= cnt[i] + CNT_ONE;
            end else if (write_en_o && (waddr_o == 5'(i)) &&
                         !(issue_fire && (issue_rd_i == 5'(i))) &&
                         (cnt[i] != '0)) begin
               cnt[i] <= cnt[i] - CNT_ONE;
            end
         end
      end
   end

endmodule

// File: tb/tb_cpu_wb_arbiter.sv
// Self-checking bench for cpu_wb_arbiter: directed scenarios with literal
// expectations plus a per-cycle comparison against a behavioural model.
module tb_cpu_wb_arbiter;

   localparam int MAXC = 3;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        issue_valid = 1'b0;
   logic [4:0]  issue_rd = '0;
   logic        issue_ready;
   logic [4:0]  raddr1 = '0;
   logic [4:0]  raddr2 = '0;
   logic        hazard1;
   logic        hazard2;
   logic        alu_valid = 1'b0;
   logic [4:0]  alu_rd = '0;
   logic [31:0] alu_data = '0;
   logic        alu_ready;
   logic        lsu_valid = 1'b0;
   logic [4:0]  lsu_rd = '0;
   logic [31:0] lsu_data = '0;
   logic        lsu_ready;
   logic [4:0]  waddr;
   logic [31:0] wdata;
   logic        write_en;
   logic        err;

   always #5 clk = ~clk;

   cpu_wb_arbiter #(.CNT_W(2)) dut (
      .clk_i(clk), .rst_i(rst),
      .issue_valid_i(issue_valid), .issue_rd_i(issue_rd),
      .issue_ready_o(issue_ready),
      .raddr1_i(raddr1), .raddr2_i(raddr2),
      .hazard1_o(hazard1), .hazard2_o(hazard2),
      .alu_valid_i(alu_valid), .alu_rd_i(alu_rd),
      .alu_data_i(alu_data), .alu_ready_o(alu_ready),
      .lsu_valid_i(lsu_valid), .lsu_rd_i(lsu_rd),
      .lsu_data_i(lsu_data), .lsu_ready_o(lsu_ready),
      .waddr_o(waddr), .wdata_o(wdata),
      .write_en_o(write_en), .err_o(err)
   );

   int pass_cnt  = 0;
   int total_cnt = 0;
   bit cmp_en    = 1'b0;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   // Behavioural model: pending-write counts as plain integers, tie
   // alternation from the number of ties seen so far.
   int          m_cnt [32];
   int          m_ties = 0;
   bit          m_we = 1'b0;
   logic [4:0]  m_waddr = '0;
   logic [31:0] m_wdata = '0;
   bit          m_err = 1'b0;
   bit          mg_alu, mg_lsu;
   logic [4:0]  mg_rd;
   logic [31:0] mg_data;
   int          m_left, m_new;

   function automatic bit m_alu_gets();
      return alu_valid && (!lsu_valid || (m_ties % 2) == 1);
   endfunction

   function automatic bit m_lsu_gets();
      return lsu_valid && !(alu_valid && (m_ties % 2) == 1);
   endfunction

   always @(posedge clk) begin
      if (rst) begin
         foreach (m_cnt[i]) m_cnt[i] = 0;
         m_ties  = 0;
         m_we    = 1'b0;
         m_waddr = '0;
         m_wdata = '0;
         m_err   = 1'b0;
      end else begin
         mg_alu  = m_alu_gets();
         mg_lsu  = m_lsu_gets();
         mg_rd   = mg_alu ? alu_rd : lsu_rd;
         mg_data = mg_alu ? alu_data : lsu_data;
         if ((mg_alu || mg_lsu) && mg_rd != 0) begin
            m_left = m_cnt[mg_rd] - ((m_we && m_waddr == mg_rd) ? 1 : 0);
            if (m_left <= 0) m_err = 1'b1;
         end
         if (alu_valid && lsu_valid) m_ties++;
         for (int r = 1; r < 32; r++) begin
            m_new = m_cnt[r];
            if (issue_valid && issue_rd == r && m_cnt[r] < MAXC) m_new++;
            if (m_we && m_waddr == r) m_new--;
            m_cnt[r] = (m_new < 0) ? 0 : m_new;
         end
         if (mg_alu || mg_lsu) begin
            m_waddr = mg_rd;
            m_wdata = mg_data;
            m_we    = (mg_rd != 0);
         end else begin
            m_we = 1'b0;
         end
      end
   end

   always @(negedge clk) begin
      if (cmp_en) begin
         chk("m_issue_ready", issue_ready,
             (issue_rd == 0) || (m_cnt[issue_rd] < MAXC));
         chk("m_hazard1", hazard1, m_cnt[raddr1] > 0);
         chk("m_hazard2", hazard2, m_cnt[raddr2] > 0);
         chk("m_alu_ready", alu_ready, m_alu_gets());
         chk("m_lsu_ready", lsu_ready, m_lsu_gets());
         chk("m_write_en", write_en, m_we);
         chk("m_waddr", waddr, m_waddr);
         chk("m_wdata", wdata, m_wdata);
         chk("m_err", err, m_err);
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic neg();
      @(negedge clk);
   endtask

   int ai, li, guard;
   bit ga, gl;
   int exp_rd [4] = '{11, 1, 12, 2};

   initial begin
      rst = 1'b1;
      cyc();
      cyc();
      rst = 1'b0;
      cmp_en = 1'b1;

      // reset state
      neg();
      chk("rst_write_en", write_en, 0);
      chk("rst_err", err, 0);
      chk("rst_waddr", waddr, 0);
      chk("rst_wdata", wdata, 0);

      // single ALU result
      cyc();
      issue_valid = 1'b1; issue_rd = 5'd5; raddr1 = 5'd5;
      neg();
      chk("s1_issue_ready", issue_ready, 1);
      chk("s1_hazard_pre", hazard1, 0);
      cyc();
      issue_valid = 1'b0;
      alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEADBEEF;
      neg();
      chk("s1_hazard_issued", hazard1, 1);
      chk("s1_alu_ready", alu_ready, 1);
      cyc();
      alu_valid = 1'b0;
      neg();
      chk("s1_write_en", write_en, 1);
      chk("s1_waddr", waddr, 5);
      chk("s1_wdata", wdata, 32'hDEADBEEF);
      chk("s1_hazard_wr", hazard1, 1);
      cyc();
      neg();
      chk("s1_write_en_off", write_en, 0);
      chk("s1_hazard_clear", hazard1, 0);

      // contention
      for (int i = 0; i < 8; i++) begin
         cyc();
         issue_valid = 1'b1;
         issue_rd = (i < 4) ? 5'(1 + i) : 5'(7 + i);
      end
      cyc();
      issue_valid = 1'b0;
      ai = 0; li = 0; guard = 0;
      while ((ai < 4 || li < 4) && guard < 20) begin
         alu_valid = (ai < 4); alu_rd = 5'(1 + ai);
         alu_data = 32'hA000_0000 + 32'(ai);
         lsu_valid = (li < 4); lsu_rd = 5'(11 + li);
         lsu_data = 32'h5000_0000 + 32'(li);
         neg();
         if (guard < 4) begin
            chk("c_lsu_grant", lsu_ready, (guard % 2) == 0);
            chk("c_alu_grant", alu_ready, (guard % 2) == 1);
         end
         if (guard >= 1 && guard <= 4)
            chk("c_waddr", waddr, exp_rd[guard-1]);
         ga = alu_ready; gl = lsu_ready;
         cyc();
         if (ga) ai++;
         if (gl) li++;
         guard++;
      end
      chk("c_drain_done", (ai == 4) && (li == 4), 1);
      alu_valid = 1'b0; lsu_valid = 1'b0;
      raddr1 = 5'd4; raddr2 = 5'd14;
      cyc();
      neg();
      chk("c_hazard1_clear", hazard1, 0);
      chk("c_hazard2_clear", hazard2, 0);

      // overflow
      for (int i = 0; i < 3; i++) begin
         issue_valid = 1'b1; issue_rd = 5'd7;
         cyc();
      end
      alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 32'd7;
      neg();
      chk("o_full", issue_ready, 0);
      cyc();
      alu_valid = 1'b0;
      neg();
      chk("o_full_wr", issue_ready, 0);
      cyc();
      neg();
      chk("o_ready_back", issue_ready, 1);
      cyc();
      issue_valid = 1'b0;
      alu_valid = 1'b1;
      cyc(); cyc(); cyc();
      alu_valid = 1'b0; raddr1 = 5'd7;
      cyc();
      neg();
      chk("o_hazard_clear", hazard1, 0);

      // simultaneous increment and decrement
      cyc();
      issue_valid = 1'b1; issue_rd = 5'd3;
      cyc();
      issue_valid = 1'b0;
      alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'd33;
      cyc();
      alu_valid = 1'b0;
      issue_valid = 1'b1; issue_rd = 5'd3; raddr2 = 5'd3;
      neg();
      chk("x_write_en", write_en, 1);
      chk("x_hazard_before", hazard2, 1);
      cyc();
      issue_valid = 1'b0;
      neg();
      chk("x_hazard_after", hazard2, 1);
      chk("x_err", err, 0);
      alu_valid = 1'b1;
      cyc();
      alu_valid = 1'b0;
      cyc();
      neg();
      chk("x_hazard_clear", hazard2, 0);

      // x0 result and issue
      alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'h1234;
      issue_valid = 1'b1; issue_rd = 5'd0; raddr1 = 5'd0;
      neg();
      chk("z_alu_ready", alu_ready, 1);
      chk("z_issue_ready", issue_ready, 1);
      chk("z_hazard", hazard1, 0);
      cyc();
      alu_valid = 1'b0; issue_valid = 1'b0;
      neg();
      chk("z_write_en", write_en, 0);
      chk("z_err", err, 0);

      // unexpected result
      lsu_valid = 1'b1; lsu_rd = 5'd9; lsu_data = 32'd99; raddr1 = 5'd9;
      cyc();
      lsu_valid = 1'b0;
      neg();
      chk("e_write_en", write_en, 1);
      chk("e_waddr", waddr, 9);
      chk("e_err", err, 1);
      cyc();
      neg();
      chk("e_no_wrap", hazard1, 0);
      issue_valid = 1'b1; issue_rd = 5'd9;
      cyc();
      issue_valid = 1'b0;
      neg();
      chk("e_hazard_one", hazard1, 1);
      chk("e_ready_one", issue_ready, 1);
      chk("e_err_sticky", err, 1);

      // reset mid-flight
      cyc();
      issue_valid = 1'b1; issue_rd = 5'd4;
      cyc();
      cyc();
      issue_valid = 1'b0;
      lsu_valid = 1'b1; lsu_rd = 5'd4; lsu_data = 32'd44;
      raddr1 = 5'd4; raddr2 = 5'd9;
      cyc();
      lsu_valid = 1'b0; rst = 1'b1;
      neg();
      chk("r_pending", write_en, 1);
      chk("r_hazard_pre", hazard1, 1);
      cyc();
      rst = 1'b0;
      neg();
      chk("r_hazard1", hazard1, 0);
      chk("r_hazard2", hazard2, 0);
      chk("r_write_en", write_en, 0);
      chk("r_err", err, 0);
      alu_valid = 1'b1; alu_rd = 5'd4; alu_data = 32'd4;
      cyc();
      alu_valid = 1'b0;
      neg();
      chk("r_late_err", err, 1);
      chk("r_late_write", write_en, 1);
      cyc();
      neg();
      chk("r_late_sat", hazard1, 0);

      cmp_en = 1'b0;
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
